// File: rtl/dmi_arbiter.sv
// DMI request/response types and a two-master round-robin arbiter in front of the
// Debug Module's single DMI slave port: one transaction in flight, bounded response latency.
package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DmiRespFailed = 2'h2;
endpackage

module dmi_arbiter #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  dm::dmi_req_t  [1:0]  req_i,
    input  logic          [1:0]  req_valid_i,
    output logic          [1:0]  req_ready_o,
    output dm::dmi_resp_t [1:0]  resp_o,
    output logic          [1:0]  resp_valid_o,
    input  logic          [1:0]  resp_ready_i,
    output dm::dmi_req_t         dm_req_o,
    output logic                 dm_req_valid_o,
    input  logic                 dm_req_ready_i,
    input  dm::dmi_resp_t        dm_resp_i,
    input  logic                 dm_resp_valid_i,
    output logic                 dm_resp_ready_o,
    output logic                 busy_o,
    output logic                 timeout_o
);
    localparam bit              TimeoutEn = (TimeoutCycles != 0);
    localparam int unsigned     CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_e;

    state_e          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    dm::dmi_req_t    req_q, req_d;
    dm::dmi_resp_t   resp_q, resp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic            grant_idx;

    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        last_d          = last_q;
        req_d           = req_q;
        resp_d          = resp_q;
        cnt_d           = cnt_q;
        drain_d         = drain_q;
        grant_idx       = 1'b0;
        req_ready_o     = '0;
        resp_o          = '0;
        resp_valid_o    = '0;
        dm_req_o        = '0;
        dm_req_valid_o  = 1'b0;
        dm_resp_ready_o = drain_q;
        timeout_o       = 1'b0;

        case (state_q)
            IDLE: begin
                // A tie goes to the master that was not served last.
                grant_idx = (&req_valid_i) ? ~last_q : req_valid_i[1];
                if (!drain_q && (|req_valid_i)) begin
                    req_ready_o[grant_idx] = 1'b1;
                    req_d   = req_i[grant_idx];
                    gnt_d   = grant_idx;
                    last_d  = grant_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                dm_req_valid_o = 1'b1;
                dm_req_o       = req_q;
                if (dm_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                dm_resp_ready_o = 1'b1;
                if (dm_resp_valid_i) begin
                    resp_d  = dm_resp_i;
                    state_d = DELIVER;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    resp_d    = '{data: '0, resp: dm::DmiRespFailed};
                    drain_d   = 1'b1;
                    timeout_o = 1'b1;
                    state_d   = DELIVER;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DELIVER: begin
                resp_valid_o[gnt_q] = 1'b1;
                resp_o[gnt_q]       = resp_q;
                if (resp_ready_i[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The DM's late answer to a timed-out request is swallowed and never reaches a master.
        if (drain_q && dm_resp_valid_i) begin
            drain_d = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            req_q   <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    assign busy_o = (state_q != IDLE) || drain_q;

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Two-port round-robin arbiter that shares the Debug Module's single DMI slave port between two DMI masters. Master 0 is the JTAG DTM path arriving through the DMI clock-domain crossing; master 1 is an on-chip debug requester. The block sits entirely in the core clock domain, between the CDC outputs and the DM. It keeps exactly one transaction outstanding, routes each response back to the master that issued it, and bounds DM response latency with a timeout.

## Interface
Parameters:
- TimeoutCycles, 256: DM response cycle limit after request acceptance; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  2 x dm::dmi_req_t  request per master (addr 7b, op 2b, data 32b).
- req_valid_i  in  2  request valid per master.
- req_ready_o  out  2  request accepted per master.
- resp_o  out  2 x dm::dmi_resp_t  response per master (data 32b, resp 2b).
- resp_valid_o  out  2  response valid per master.
- resp_ready_i  in  2  master accepts response.
- dm_req_o  out  dm::dmi_req_t  request to DM.
- dm_req_valid_o  out  1  request to DM valid.
- dm_req_ready_i  in  1  DM accepts request.
- dm_resp_i  in  dm::dmi_resp_t  response from DM.
- dm_resp_valid_i  in  1  DM response valid.
- dm_resp_ready_o  out  1  arbiter accepts DM response.
- busy_o  out  1  high when state != IDLE or drain_q is set.
- timeout_o  out  1  single-cycle pulse when a timeout fires.

## Operation
- State machine: IDLE, REQ, RESP, DELIVER.
- Registers: state; gnt_q (granted master); last_q (round-robin pointer); req_q; resp_q; cnt_q of width $clog2(TimeoutCycles+1); drain_q.
- IDLE (grant logic is combinational):
  - No grant while drain_q = 1.
  - One valid master: grant it.
  - Both valid: grant !last_q.
  - req_ready_o[g] = 1 in the grant cycle only.
  - On grant: req_q <= req_i[g], gnt_q <= g, last_q <= g, go to REQ.
- REQ:
  - dm_req_valid_o = 1; dm_req_o = req_q, held stable.
  - On dm_req_ready_i: cnt_q <= 0, go to RESP.
- RESP:
  - dm_resp_ready_o = 1.
  - On dm_resp_valid_i: resp_q <= dm_resp_i, go to DELIVER.
  - Otherwise cnt_q increments.
  - If TimeoutCycles != 0 and cnt_q == TimeoutCycles-1 with no response that cycle:
    - resp_q <= {data 32'h0, resp 2'h2};
    - drain_q <= 1; timeout_o pulses; go to DELIVER.
- DELIVER:
  - resp_valid_o[gnt_q] = 1; resp_o[gnt_q] = resp_q.
  - On resp_ready_i[gnt_q]: go to IDLE.
- Drain behaviour:
  - While drain_q = 1, dm_resp_ready_o = 1 in every state.
  - A late DM response is discarded and clears drain_q.
  - This applies in DELIVER and in IDLE.
- Ungranted master:
  - Its req_ready_o and resp_valid_o stay 0.
  - Its resp_o is driven 0.
- dm_resp_ready_o is 0 in IDLE, REQ and DELIVER unless drain_q = 1.

## Timing
- Reset values:
  - Outputs: all req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, busy_o and timeout_o are 0; dm_req_o and resp_o are 0.
  - Registers: state = IDLE, last_q = 1 (master 0 wins the first tie), drain_q = 0, cnt_q = 0.
- Reset mid-transaction: rst_i aborts at the next edge. No response is delivered and no drain is armed.
- Latency, for grant in cycle t:
  - dm_req_valid_o rises at t+1.
  - DM response accepted in cycle u: resp_valid_o rises at u+1.
  - Master response handshake in cycle v: IDLE at v+1, next grant possible at v+1.
- Throughput: minimum 4 cycles per transaction with a zero-wait DM.
- Timeout: a request accepted in cycle r with no response gets its error response valid at r+TimeoutCycles+1.
- Response in the same cycle the counter expires: the response wins; no timeout, no drain.
- A grant and a late-response discard cannot coincide, because grants are blocked while drain_q = 1.
- A master deasserting req_valid_i while not granted is legal; nothing is latched.

## Test plan
- Single master 0 write (addr 0x10, op 2, data 0xDEADBEEF), DM ready immediately, response {0x0, 0}:
  - dm_req_valid_o at t+1 with the same fields;
  - resp_valid_o[0] at t+3; resp_valid_o[1] stays 0.
- Both masters valid continuously for 4 transactions from reset:
  - grant order 0,1,0,1;
  - each response routed only to the issuing master with its data (0xA0, 0xB1, ...).
- DM holds dm_req_ready_i low for 5 cycles, master 1 holds resp_ready_i low for 3 cycles:
  - dm_req_o stable throughout; resp_o[1] held;
  - no new grant until the response handshake completes.
- TimeoutCycles=8, DM never responds:
  - timeout_o pulses once; resp_o[g] = {0, 2'h2};
  - a late response 20 cycles later is consumed with dm_resp_ready_o = 1 and not forwarded;
  - the next grant follows only afterwards.
- DM responds in exactly the expiry cycle: normal data delivered, timeout_o stays 0, drain_q stays 0.
- rst_i asserted in RESP:
  - next cycle all outputs 0, state IDLE;
  - a subsequent tie grants master 0.
